spi_master_mcs: RTL and testbench
=================================

SPI_MASTER_MCS -- requirements
Module: spi_master_mcs

Interface
REQ-001 SHALL have parameter SPI_DATA_WIDTH, default 32: maximum bits per transfer.
REQ-002 SHALL have parameter SPI_CLOCK_DIVIDER_WIDTH, default 5: width of the clock divider input.
REQ-003 SHALL have parameter SPI_CS_COUNT, default 4: number of chip selects, minimum 1.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous active-high reset.
- i_start  in  1  transfer request.
- o_ready  out  1  idle, able to accept a request.
- i_cs_select  in  $clog2(SPI_CS_COUNT) (minimum 1)  target slave index.
- i_length  in  $clog2(SPI_DATA_WIDTH)  transfer bit count minus 1.
- i_clock_polarity  in  1  CPOL.
- i_clock_phase  in  1  CPHA.
- i_spi_clock_divider  in  SPI_CLOCK_DIVIDER_WIDTH  half-period select.
- i_data_in  in  SPI_DATA_WIDTH  transmit word, right-aligned.
- o_data_out  out  SPI_DATA_WIDTH  received word, right-aligned.
- o_done  out  1  single-cycle completion pulse.
- o_busy  out  1  transfer in progress.
- o_spi_cs_n  out  SPI_CS_COUNT  active-low chip selects.
- o_spi_clock  out  1  SCLK.
- o_spi_mosi  out  1  MOSI.
- i_spi_miso  in  1  MISO.

Function
REQ-005 SHALL accept a request only on a cycle where i_start and o_ready are both 1; i_start while o_ready=0 is ignored, not queued.
REQ-006 SHALL capture i_cs_select, i_length, CPOL, CPHA, divider and i_data_in on acceptance; later changes to these inputs do not affect the transfer in flight.
REQ-007 SHALL define half-period H = i_spi_clock_divider+1 system clocks (divider 0 gives i_clock/2).
REQ-008 SHALL use the FSM IDLE -> LEAD -> XFER -> TRAIL -> GAP -> IDLE.
- LEAD, TRAIL and GAP each last H cycles.
- XFER lasts 2*H*(i_length+1) cycles.
REQ-009 SHALL hold o_ready=1 only in IDLE, and o_busy=1 in every state other than IDLE.
REQ-010 SHALL drive o_spi_cs_n[i_cs_select] low from entry to LEAD until exit from TRAIL; all other CS lines stay high.
REQ-011 SHALL, if i_cs_select >= SPI_CS_COUNT, run the transfer with all CS lines high and complete normally.
REQ-012 SHALL hold o_spi_clock at the captured CPOL outside XFER, and toggle it every H cycles in XFER, giving exactly i_length+1 clock periods.
REQ-013 SHALL shift MSB-first from bit i_length.
- CPHA=0: MOSI valid at LEAD entry; sample MISO on each leading edge; shift on each trailing edge.
- CPHA=1: shift on each leading edge; sample on each trailing edge.
REQ-014 SHALL right-align the received bits in o_data_out, with bits above i_length equal to 0.
REQ-015 SHALL update o_data_out only at the end of TRAIL, and hold it until the next completion.
REQ-016 SHALL pulse o_done for exactly one cycle on the GAP -> IDLE transition; o_ready=1 on the following cycle.
REQ-017 SHALL, when i_start is held high continuously, accept a new transfer on the first IDLE cycle, giving back-to-back transfers separated by a GAP of H cycles.
REQ-018 SHALL drive MOSI low in IDLE.

Reset
REQ-019 SHALL, on i_reset assertion at any time including mid-transfer, immediately force all outputs to their reset values:
- State IDLE, o_ready=1, o_busy=0, o_done=0.
- o_spi_cs_n all 1, o_spi_clock=0, o_spi_mosi=0, o_data_out=0.
REQ-020 SHALL raise no o_done pulse for a transfer aborted by reset.

Configuration
REQ-021 SHALL support macro SPI_MASTER_MCS_LOOPBACK_EN.
- Defined: adds input i_loopback (1 bit, captured at acceptance); when 1, the internally sampled MISO equals o_spi_mosi and i_spi_miso is ignored.
- Undefined: no i_loopback port, and i_spi_miso is always used.

Structure
REQ-022 SHALL place in package spi_pkg:
- the FSM state enum typedef (spi_state_t);
- the mode struct spi_mode_t (cpol, cpha).
REQ-023 SHALL implement the half-period tick and edge generation in sub-module spi_clock_gen (inputs: divider, enable, CPOL; outputs: SCLK, leading-edge pulse, trailing-edge pulse).

Verification
REQ-024 SHALL cover these directed scenarios:
- Mode 0, divider 0, length 7, data 0xA5, cs_select 2, MISO tied to MOSI externally -> cs_n=4'b1011 during transfer; 8 SCLK pulses; o_data_out=0x000000A5; one o_done pulse.
- Mode 3, divider 3, length 31, data 0xDEADBEEF, MISO driven by a slave model returning 0x12345678 -> SCLK idles high; SCLK period 8 cycles; o_data_out=0x12345678.
- i_start held high, two transfers of length 3 -> second transfer begins exactly H cycles after the first TRAIL ends; two o_done pulses.
- i_reset asserted mid-XFER of a 16-bit transfer -> same cycle: cs_n all 1, SCLK 0, o_busy 0; no o_done.
- cs_select 7 with SPI_CS_COUNT=4 -> all CS stay high; transfer completes; o_done pulses.
- With SPI_MASTER_MCS_LOOPBACK_EN, i_loopback=1, MISO stuck at 0, data 0x3C, length 7 -> o_data_out=0x3C.

Source files
------------

// File: rtl/spi_master_mcs_pkg.sv
// Shared types for the SPI master: FSM state encoding, captured mode bits and
// the chip-select index width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int cs_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/spi_master_mcs_if.sv
// Request/SPI signal bundle for spi_master_mcs. The optional i_loopback member
// exists only when SPI_MASTER_MCS_LOOPBACK_EN is defined.
interface spi_master_mcs_if
    import spi_pkg::*;
#(
    parameter int SPI_DATA_WIDTH          = 32,
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 5,
    parameter int SPI_CS_COUNT            = 4
);
    localparam int LW  = $clog2(SPI_DATA_WIDTH);
    localparam int CSW = cs_width(SPI_CS_COUNT);

    logic                               i_start;
    logic                               o_ready;
    logic [CSW-1:0]                     i_cs_select;
    logic [LW-1:0]                      i_length;
    logic                               i_clock_polarity;
    logic                               i_clock_phase;
    logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] i_spi_clock_divider;
    logic [SPI_DATA_WIDTH-1:0]          i_data_in;
    logic [SPI_DATA_WIDTH-1:0]          o_data_out;
    logic                               o_done;
    logic                               o_busy;
    logic [SPI_CS_COUNT-1:0]            o_spi_cs_n;
    logic                               o_spi_clock;
    logic                               o_spi_mosi;
    logic                               i_spi_miso;
`ifdef SPI_MASTER_MCS_LOOPBACK_EN
    logic                               i_loopback;
`endif
    spi_state_t                         o_state;

    modport master (
        input  i_start, i_cs_select, i_length, i_clock_polarity, i_clock_phase,
        input  i_spi_clock_divider, i_data_in, i_spi_miso,
`ifdef SPI_MASTER_MCS_LOOPBACK_EN
        input  i_loopback,
`endif
        output o_ready, o_data_out, o_done, o_busy, o_spi_cs_n, o_spi_clock,
        output o_spi_mosi, o_state
    );

    modport slave (
        output i_start, i_cs_select, i_length, i_clock_polarity, i_clock_phase,
        output i_spi_clock_divider, i_data_in, i_spi_miso,
`ifdef SPI_MASTER_MCS_LOOPBACK_EN
        output i_loopback,
`endif
        input  o_ready, o_data_out, o_done, o_busy, o_spi_cs_n, o_spi_clock,
        input  o_spi_mosi, o_state
    );

endinterface

// File: rtl/spi_master_mcs_clock_gen.sv
// SCLK generator: toggles every divider_i+1 cycles while enabled and flags the
// cycle before each leading (away from idle) and trailing (back to idle) edge.
module spi_clock_gen #(
    parameter int DIV_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    input  logic                 enable_i,
    input  logic                 cpol_i,
    output logic                 sclk_o,
    output logic                 lead_o,
    output logic                 trail_o
);
    logic [DIV_WIDTH-1:0] tick_q, tick_d;
    logic                 phase_q, phase_d;
    logic                 half_end;

    // phase_q is 0 at the idle level, so SCLK follows CPOL whenever disabled.
    assign half_end = enable_i && (tick_q == divider_i);
    assign lead_o   = half_end && !phase_q;
    assign trail_o  = half_end && phase_q;
    assign sclk_o   = cpol_i ^ phase_q;

    always_comb begin
        tick_d  = tick_q;
        phase_d = phase_q;
        if (!enable_i) begin
            tick_d  = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            tick_d  = '0;
            phase_d = ~phase_q;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_master_mcs.sv
// SPI master with multiple chip selects and per-transfer CPOL/CPHA/length/divider.
// Define SPI_MASTER_MCS_LOOPBACK_EN to add the captured i_loopback MISO<-MOSI path.
module spi_master_mcs
    import spi_pkg::*;
#(
    parameter int SPI_DATA_WIDTH          = 32,
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 5,
    parameter int SPI_CS_COUNT            = 4
) (
    input logic              i_clock,
    input logic              i_reset,
    spi_master_mcs_if.master bus
);
    localparam int W   = SPI_DATA_WIDTH;
    localparam int DW  = SPI_CLOCK_DIVIDER_WIDTH;
    localparam int LW  = $clog2(W);
    localparam int CSW = cs_width(SPI_CS_COUNT);

    spi_state_t     state_q, state_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  div_q, div_d;
    logic [CSW-1:0] cs_q, cs_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  idx_q, idx_d;
    logic [LW-1:0]  bit_q, bit_d;
    spi_mode_t      mode_q, mode_d;
    logic [W-1:0]   tx_q, tx_d;
    logic [W-1:0]   rx_q, rx_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           lb_q, lb_d;

    logic half_done, cs_active, mosi, miso_eff;
    logic sclk, sclk_lead, sclk_trail, sample_en, shift_en;
    logic [CSW:0] cs_ext;

    spi_clock_gen #(.DIV_WIDTH(DW)) u_clock_gen (
        .clk_i     (i_clock),
        .rst_i     (i_reset),
        .divider_i (div_q),
        .enable_i  (state_q == ST_XFER),
        .cpol_i    (mode_q.cpol),
        .sclk_o    (sclk),
        .lead_o    (sclk_lead),
        .trail_o   (sclk_trail)
    );

    assign half_done = (cnt_q == div_q);
    assign cs_active = (state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_TRAIL);
    assign mosi      = cs_active ? tx_q[idx_q] : 1'b0;
    // CPHA=1 presents the first bit on the first leading edge, so it is not shifted away there.
    assign sample_en = mode_q.cpha ? sclk_trail : sclk_lead;
    assign shift_en  = mode_q.cpha ? (sclk_lead && (bit_q != '0)) : sclk_trail;

`ifdef SPI_MASTER_MCS_LOOPBACK_EN
    assign miso_eff = lb_q ? mosi : bus.i_spi_miso;
`else
    assign miso_eff = bus.i_spi_miso;
    assign lb_d     = 1'b0;
`endif

    // Request handshake: a transfer is accepted on a cycle where i_start and o_ready
    // are both high; i_start without o_ready is dropped, never queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        cs_d    = cs_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
`ifdef SPI_MASTER_MCS_LOOPBACK_EN
        lb_d    = lb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                    div_d   = bus.i_spi_clock_divider;
                    cs_d    = bus.i_cs_select;
                    len_d   = bus.i_length;
                    idx_d   = bus.i_length;
                    bit_d   = '0;
                    mode_d  = '{cpol: bus.i_clock_polarity, cpha: bus.i_clock_phase};
                    tx_d    = bus.i_data_in;
                    rx_d    = '0;
`ifdef SPI_MASTER_MCS_LOOPBACK_EN
                    lb_d    = bus.i_loopback;
`endif
                end
            end
            ST_LEAD: begin
                if (half_done) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (sample_en) rx_d = {rx_q[W-2:0], miso_eff};
                if (shift_en && (idx_q != '0)) idx_d = idx_q - 1'b1;
                if (sclk_trail) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == len_q) state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (half_done) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    dout_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (half_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            cs_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            mode_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            lb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            cs_q    <= cs_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            lb_q    <= lb_d;
        end
    end

    // An out-of-range select matches no line, so every CS stays high.
    assign cs_ext = {1'b0, cs_q};
    always_comb begin
        bus.o_spi_cs_n = '1;
        for (int i = 0; i < SPI_CS_COUNT; i++) begin
            if (cs_active && (cs_ext == (CSW+1)'(i))) bus.o_spi_cs_n[i] = 1'b0;
        end
    end

    assign bus.o_ready     = (state_q == ST_IDLE);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_done      = (state_q == ST_GAP) && half_done;
    assign bus.o_data_out  = dout_q;
    assign bus.o_spi_clock = sclk;
    assign bus.o_spi_mosi  = mosi;
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed self-checking bench for spi_master_mcs (main instance with 4 chip
// selects, second instance with 3 so an out-of-range select is representable).
module tb_spi_master_mcs;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;

  logic [1:0]  miso_sel;
  logic [31:0] slave_word;
  logic [31:0] slave_sh;
  logic        sclk_d;

  int          r_busy, r_leads, r_period, r_done;
  logic [3:0]  r_cs_and;
  logic        r_first_sclk, r_ready_after, r_timeout;
  logic [31:0] r_dout_first;

  spi_master_mcs_if #(.SPI_DATA_WIDTH(32), .SPI_CLOCK_DIVIDER_WIDTH(5), .SPI_CS_COUNT(4)) bus ();
  spi_master_mcs_if #(.SPI_DATA_WIDTH(32), .SPI_CLOCK_DIVIDER_WIDTH(5), .SPI_CS_COUNT(3)) bus3 ();

  spi_master_mcs #(.SPI_DATA_WIDTH(32), .SPI_CLOCK_DIVIDER_WIDTH(5), .SPI_CS_COUNT(4)) u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  spi_master_mcs #(.SPI_DATA_WIDTH(32), .SPI_CLOCK_DIVIDER_WIDTH(5), .SPI_CS_COUNT(3)) u_dut3 (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus3.master)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // 0: MISO wired to MOSI, 1: shift-register slave, 2: stuck low
  assign bus.i_spi_miso  = (miso_sel == 2'd0) ? bus.o_spi_mosi :
                           (miso_sel == 2'd1) ? slave_sh[31] : 1'b0;
  assign bus3.i_spi_miso = bus3.o_spi_mosi;

  // Mode-3 slave: MSB first, next bit after each rising SCLK (its trailing edge).
  always @(posedge clk) begin
    sclk_d <= bus.o_spi_clock;
    if (bus.o_state == ST_LEAD) slave_sh <= slave_word;
    else if (bus.o_state == ST_XFER && bus.o_spi_clock && !sclk_d) slave_sh <= slave_sh << 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_xfer(input logic [1:0] cs, input logic [4:0] len, input logic cpol,
                          input logic cpha, input logic [4:0] div, input logic [31:0] data);
    logic prev;
    logic got_done;
    int t1, t2;
    @(negedge clk);
    bus.i_cs_select = cs;
    bus.i_length = len;
    bus.i_clock_polarity = cpol;
    bus.i_clock_phase = cpha;
    bus.i_spi_clock_divider = div;
    bus.i_data_in = data;
    bus.i_start = 1'b1;
    @(negedge clk);
    // scramble inputs: the accepted transfer must use its captured copies
    bus.i_start = 1'b0;
    bus.i_cs_select = ~cs;
    bus.i_length = ~len;
    bus.i_clock_polarity = ~cpol;
    bus.i_clock_phase = ~cpha;
    bus.i_spi_clock_divider = ~div;
    bus.i_data_in = ~data;
    r_busy = 0; r_leads = 0; r_done = 0; r_cs_and = '1;
    r_ready_after = 1'b0; r_timeout = 1'b1;
    prev = cpol; got_done = 1'b0; t1 = -1; t2 = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        r_first_sclk = bus.o_spi_clock;
        r_dout_first = bus.o_data_out;
      end
      if (bus.o_busy) r_busy++;
      r_cs_and &= bus.o_spi_cs_n;
      if (bus.o_spi_clock != prev && bus.o_spi_clock != cpol) begin
        r_leads++;
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      prev = bus.o_spi_clock;
      if (bus.o_done) r_done++;
      if (got_done) begin
        r_ready_after = bus.o_ready;
        r_timeout = 1'b0;
        break;
      end
      if (bus.o_done) got_done = 1'b1;
    end
    r_period = t2 - t1;
  endtask

  // ---------------- stimulus ----------------
  int dcnt, rcnt, t_acc, t_rise, b3, d3, quiet_busy;
  logic [31:0] dout_mid;
  logic [2:0]  cs_and3;

  initial begin
    rst = 1'b1;
    miso_sel = 2'd0;
    slave_word = 32'h0;
    bus.i_start = 1'b0; bus.i_cs_select = '0; bus.i_length = '0;
    bus.i_clock_polarity = 1'b0; bus.i_clock_phase = 1'b0;
    bus.i_spi_clock_divider = '0; bus.i_data_in = '0;
    bus3.i_start = 1'b0; bus3.i_cs_select = '0; bus3.i_length = '0;
    bus3.i_clock_polarity = 1'b0; bus3.i_clock_phase = 1'b0;
    bus3.i_spi_clock_divider = '0; bus3.i_data_in = '0;
`ifdef SPI_MASTER_MCS_LOOPBACK_EN
    bus.i_loopback = 1'b0;
    bus3.i_loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.o_state), 32'(ST_IDLE));
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_cs_n", 32'(bus.o_spi_cs_n), 32'hF);
    check("rst_sclk", 32'(bus.o_spi_clock), 32'd0);
    check("rst_mosi", 32'(bus.o_spi_mosi), 32'd0);
    check("rst_dout", bus.o_data_out, 32'h0);
    rst = 1'b0;

    // Mode 0, divider 0, 8 bits, MISO wired to MOSI, slave 2
    miso_sel = 2'd0;
    run_xfer(2'd2, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0000_00A5);
    check("m0_timeout", 32'(r_timeout), 32'd0);
    check("m0_cs_n", 32'(r_cs_and), 32'hB);
    check("m0_sclk_pulses", r_leads, 32'd8);
    check("m0_busy_cycles", r_busy, 32'd19);
    check("m0_done_pulses", r_done, 32'd1);
    check("m0_ready_after", 32'(r_ready_after), 32'd1);
    check("m0_dout", bus.o_data_out, 32'h0000_00A5);
    check("m0_mosi_idle", 32'(bus.o_spi_mosi), 32'd0);

    // Mode 3, divider 3 (H=4), 32 bits from the slave model
    miso_sel = 2'd1;
    slave_word = 32'h1234_5678;
    run_xfer(2'd0, 5'd31, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    check("m3_timeout", 32'(r_timeout), 32'd0);
    check("m3_sclk_idle_hi", 32'(r_first_sclk), 32'd1);
    check("m3_dout_held", r_dout_first, 32'h0000_00A5);
    check("m3_sclk_period", r_period, 32'd8);
    check("m3_sclk_pulses", r_leads, 32'd32);
    check("m3_busy_cycles", r_busy, 32'd268);
    check("m3_cs_n", 32'(r_cs_and), 32'hE);
    check("m3_done_pulses", r_done, 32'd1);
    check("m3_dout", bus.o_data_out, 32'h1234_5678);

    // Back-to-back with i_start held: 4-bit transfers, H=2
    miso_sel = 2'd0;
    @(negedge clk);
    bus.i_cs_select = 2'd0; bus.i_length = 5'd3; bus.i_clock_polarity = 1'b0;
    bus.i_clock_phase = 1'b0; bus.i_spi_clock_divider = 5'd1;
    bus.i_data_in = 32'h9; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_data_in = 32'h6;
    dcnt = 0; rcnt = 0; t_acc = -1; t_rise = -1; dout_mid = '0;
    for (int i = 0; i < 500; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.o_done) dcnt++;
      if (bus.o_ready) begin
        rcnt++;
        t_acc = i;
        dout_mid = bus.o_data_out;
      end
      if (bus.o_busy && bus.o_spi_cs_n == 4'hF && t_rise < 0) t_rise = i;
      if (rcnt > 0 && bus.o_busy) bus.i_start = 1'b0;
      if (dcnt == 2) break;
    end
    bus.i_start = 1'b0;
    quiet_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_busy) quiet_busy++;
    end
    check("b2b_done_pulses", dcnt, 32'd2);
    check("b2b_idle_cycles", rcnt, 32'd1);
    check("b2b_restart_gap", t_acc - t_rise, 32'd2);
    check("b2b_first_dout", dout_mid, 32'h9);
    check("b2b_second_dout", bus.o_data_out, 32'h6);
    check("b2b_no_third", quiet_busy, 32'd0);

    // Reset in the middle of a 16-bit CPOL=1 transfer
    @(negedge clk);
    bus.i_cs_select = 2'd1; bus.i_length = 5'd15; bus.i_clock_polarity = 1'b1;
    bus.i_clock_phase = 1'b0; bus.i_spi_clock_divider = 5'd1;
    bus.i_data_in = 32'hBEEF; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (8) @(negedge clk);
    check("rstx_mid_state", 32'(bus.o_state), 32'(ST_XFER));
    check("rstx_mid_cs_n", 32'(bus.o_spi_cs_n), 32'hD);
    rst = 1'b1;
    #1;
    check("rstx_cs_n", 32'(bus.o_spi_cs_n), 32'hF);
    check("rstx_sclk", 32'(bus.o_spi_clock), 32'd0);
    check("rstx_busy", 32'(bus.o_busy), 32'd0);
    check("rstx_ready", 32'(bus.o_ready), 32'd1);
    check("rstx_done", 32'(bus.o_done), 32'd0);
    check("rstx_mosi", 32'(bus.o_spi_mosi), 32'd0);
    check("rstx_dout", bus.o_data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy) dcnt++;
    end
    check("rstx_no_done", dcnt, 32'd0);

    // Out-of-range select on the 3-CS instance
    @(negedge clk);
    bus3.i_cs_select = 2'd3; bus3.i_length = 5'd7; bus3.i_clock_polarity = 1'b0;
    bus3.i_clock_phase = 1'b0; bus3.i_spi_clock_divider = 5'd0;
    bus3.i_data_in = 32'h5A; bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    cs_and3 = '1; b3 = 0; d3 = 0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      cs_and3 &= bus3.o_spi_cs_n;
      if (bus3.o_busy) b3++;
      if (bus3.o_done) d3++;
      if (bus3.o_ready) break;
    end
    check("oor_cs_n", 32'(cs_and3), 32'h7);
    check("oor_busy_cycles", b3, 32'd19);
    check("oor_done_pulses", d3, 32'd1);
    check("oor_dout", bus3.o_data_out, 32'h5A);

`ifdef SPI_MASTER_MCS_LOOPBACK_EN
    // Internal loopback with MISO stuck low
    miso_sel = 2'd2;
    bus.i_loopback = 1'b1;
    run_xfer(2'd1, 5'd7, 1'b0, 1'b0, 5'd0, 32'h3C);
    bus.i_loopback = 1'b0;
    check("lb_timeout", 32'(r_timeout), 32'd0);
    check("lb_dout", bus.o_data_out, 32'h3C);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end

endmodule
